// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word holding register.
// Words stream out back to back on x with no gap cycles while a
// successor is available; x idles at IDLE_BIT otherwise.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_full;
    logic [CW-1:0]    r_cnt;
    logic             r_x;
    logic             r_x_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_ready;

    logic             w_accept;
    logic [WIDTH-1:0] w_load;

    // Bit that leaves first from a word in the configured order.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its outgoing bit removed, next bit moved into place.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Handshake and the word that reloads the shifter (held word wins).
    assign w_accept = din_valid & r_ready;
    assign w_load   = r_full ? r_hold : din;

    // The shifter holds the not-yet-sent bits; r_x is the bit on the wire.
    // All outputs are computed as next-state values so they stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_hold    <= '0;
            r_full    <= 1'b0;
            r_cnt     <= '0;
            r_x       <= IDLE_BIT;
            r_x_valid <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Holding register is always empty here: load shifter directly.
                    r_last  <= 1'b0;
                    r_cnt   <= '0;
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_shift   <= advance(din);
                        r_x       <= first_bit(din);
                        r_x_valid <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end else begin
                        r_x       <= IDLE_BIT;
                        r_x_valid <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == CNT_LAST) begin
                        // Last bit on the wire: chain the next word with no gap.
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                        r_full  <= 1'b0;
                        r_ready <= 1'b1;
                        if (r_full || w_accept) begin
                            r_shift   <= advance(w_load);
                            r_x       <= first_bit(w_load);
                            r_x_valid <= 1'b1;
                            r_busy    <= 1'b1;
                        end else begin
                            r_x       <= IDLE_BIT;
                            r_x_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end else begin
                        r_shift   <= advance(r_shift);
                        r_x       <= first_bit(r_shift);
                        r_x_valid <= 1'b1;
                        r_last    <= (r_cnt == CNT_PEN);
                        r_cnt     <= r_cnt + CW'(1);
                        r_busy    <= 1'b1;
                        if (w_accept) begin
                            r_hold  <= din;
                            r_full  <= 1'b1;
                            r_ready <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign din_ready = r_ready;
    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign last      = r_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance run
// side by side. Accepted words are expanded into {bit,last} entries on a
// per-instance queue and popped as x_valid cycles appear.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din0 = '0, din1 = '0;
    logic         dv0 = 1'b0, dv1 = 1'b0;
    logic         rdy0, x0, xv0, last0, busy0;
    logic         rdy1, x1, xv1, last1, busy1;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
        .clk(clk), .reset(reset), .din(din0), .din_valid(dv0), .din_ready(rdy0),
        .x(x0), .x_valid(xv0), .last(last0), .busy(busy0)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .reset(reset), .din(din1), .din_valid(dv1), .din_ready(rdy1),
        .x(x1), .x_valid(xv1), .last(last1), .busy(busy1)
    );

    always #5 clk = ~clk;

    logic [1:0] q0[$];
    logic [1:0] q1[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input int k, input logic [W-1:0] w, input bit msb);
        logic b;
        logic [1:0] e;
        for (int i = 0; i < W; i++) begin
            b = msb ? w[W-1-i] : w[i];
            e = {b, (i == W-1)};
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Queue non-empty <=> a word bit is due; more than W entries <=> a word is held.
    task automatic check_dut(input int k, input logic xo, input logic xv,
                             input logic ls, input logic bz, input logic rd);
        int sz;
        logic [1:0] e;
        sz = (k == 0) ? q0.size() : q1.size();
        chk($sformatf("d%0d x_valid", k), xv, sz > 0);
        chk($sformatf("d%0d busy", k), bz, sz > 0);
        chk($sformatf("d%0d din_ready", k), rd, sz <= W);
        if (sz > 0) begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("d%0d x", k), xo, e[1]);
            chk($sformatf("d%0d last", k), ls, e[0]);
        end else begin
            chk($sformatf("d%0d idle x", k), xo, 1'b1);
            chk($sformatf("d%0d idle last", k), ls, 1'b0);
        end
    endtask

    // One clock: sample handshake before the edge, update model, check after it.
    task automatic step();
        logic a0, a1, rs;
        logic [W-1:0] w0, w1;
        a0 = dv0 && rdy0;
        a1 = dv1 && rdy1;
        w0 = din0;
        w1 = din1;
        rs = reset;
        @(posedge clk);
        if (rs) begin
            q0.delete();
            q1.delete();
        end else begin
            if (a0) push_word(0, w0, 1'b1);
            if (a1) push_word(1, w1, 1'b0);
        end
        #1;
        check_dut(0, x0, xv0, last0, busy0, rdy0);
        check_dut(1, x1, xv1, last1, busy1, rdy1);
    endtask

    initial begin
        // Reset state
        repeat (2) step();
        reset = 1'b0;

        // Single word from IDLE: A5 MSB-first, 01 LSB-first
        din0 = 8'hA5; dv0 = 1'b1;
        din1 = 8'h01; dv1 = 1'b1;
        step();
        dv0 = 1'b0; dv1 = 1'b0;
        chk("a5 first bit", x0, 1'b1);
        chk("01 lsb first bit", x1, 1'b1);
        repeat (10) step();

        // Back-to-back words with the second held
        din0 = 8'hA5; dv0 = 1'b1;
        step();
        din0 = 8'h3C;
        step();
        dv0 = 1'b0;
        chk("held ready low", rdy0, 1'b0);
        repeat (18) step();

        // Word offered exactly in the last-bit cycle
        din0 = 8'hA5; dv0 = 1'b1;
        step();
        dv0 = 1'b0;
        repeat (7) step();
        chk("last-bit cycle", last0, 1'b1);
        din0 = 8'hC3; dv0 = 1'b1;
        step();
        dv0 = 1'b0;
        chk("no gap valid", xv0, 1'b1);
        chk("no gap first bit", x0, 1'b1);
        repeat (9) step();

        // din changing while ready is low must be ignored
        din0 = 8'hF0; dv0 = 1'b1;
        step();
        din0 = 8'h0F;
        step();
        for (int i = 0; i < 6; i++) begin
            din0 = 8'($urandom);
            step();
        end
        dv0 = 1'b0;
        repeat (12) step();

        // Reset mid-word with a held word, accept offered on the reset edge
        din0 = 8'hA5; dv0 = 1'b1;
        step();
        din0 = 8'h3C;
        step();
        dv0 = 1'b0;
        repeat (2) step();
        chk("4th bit of a5", x0, 1'b0);
        reset = 1'b1; din0 = 8'h96; dv0 = 1'b1;
        step();
        chk("reset x", x0, 1'b1);
        chk("reset x_valid", xv0, 1'b0);
        chk("reset busy", busy0, 1'b0);
        chk("reset din_ready", rdy0, 1'b1);
        reset = 1'b0;
        step();
        dv0 = 1'b0;
        chk("accept after reset", xv0, 1'b1);
        repeat (10) step();

        // Random traffic on both instances
        for (int i = 0; i < 80; i++) begin
            dv0 = 1'($urandom_range(0, 1)); din0 = 8'($urandom);
            dv1 = 1'($urandom_range(0, 1)); din1 = 8'($urandom);
            step();
        end
        dv0 = 1'b0; dv1 = 1'b0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
